// File: rtl/shifter_pkg.sv
// Shared types for the operand-2 shifter: shift-type encoding and the decoded
// control word passed between the decode and execute stages.
package shifter_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned AMT_W      = 7;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_t;

  // pass: result is the operand untouched; over: LSL/LSR amount beyond DATA_W
  typedef struct packed {
    shift_t             sh_type;
    logic               pass;
    logic               rrx;
    logic               over;
    logic [AMT_W-1:0]   amt;
    logic               cin;
  } shift_ctrl_t;

endpackage

// File: rtl/rot_right.sv
// Combinational rotate-right of a DATA_W word by amt_i positions.
module rot_right #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AMT_W  = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [AMT_W-1:0]  amt_i,
  output logic [DATA_W-1:0] data_o
);

  localparam int unsigned SW = AMT_W + 1;

  logic [SW-1:0] lamt;

  // amt_i == 0 makes lamt == DATA_W, so the left term vanishes
  assign lamt   = SW'(DATA_W) - {1'b0, amt_i};
  assign data_o = (data_i >> amt_i) | (data_i << lamt);

endmodule

// File: rtl/shifter_operand_unit.sv
// Operand-2 shifter: decode stage, then shift/rotate and output register.
// Carry handling is built only when SHIFTER_CARRY_EN is defined.
module shifter_operand_unit
  import shifter_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned PIPE_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              imm_en,
  input  logic [11:0]       shift_operand,
  input  logic [DATA_W-1:0] val_rm,
  input  logic [7:0]        val_rs,
  input  logic              carry_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] val2,
  output logic              carry_out
);

  localparam int unsigned LW = $clog2(DATA_W);
  localparam int unsigned XW = DATA_W + 1;

  logic              cin_eff;
  logic [7:0]        n_amt;
  shift_ctrl_t       dec_ctrl;
  logic [DATA_W-1:0] dec_rm;
  shift_ctrl_t       ex_ctrl;
  logic [DATA_W-1:0] ex_rm;
  logic              ex_vld;
  logic              out_adv;
  logic              out_load;
  logic [XW-1:0]     lsl_ext;
  logic [XW-1:0]     lsr_ext;
  logic [XW-1:0]     asr_ext;
  logic [DATA_W-1:0] ror_val;
  logic [DATA_W-1:0] res_val;
  logic              res_c;
  logic              out_vld_q, out_vld_d;
  logic [DATA_W-1:0] val2_q, val2_d;

`ifdef SHIFTER_CARRY_EN
  assign cin_eff = carry_in;
`else
  logic unused_carry;
  assign cin_eff      = 1'b0;
  assign unused_carry = carry_in ^ res_c;
`endif

  // Decode: fold the zero-amount special cases and clamp large amounts
  always_comb begin
    dec_rm           = val_rm;
    dec_ctrl         = '0;
    dec_ctrl.sh_type = shift_t'(shift_operand[6:5]);
    dec_ctrl.cin     = cin_eff;
    n_amt            = shift_operand[4] ? val_rs : 8'(shift_operand[11:7]);
    if (imm_en) begin
      dec_rm           = DATA_W'(shift_operand[7:0]);
      dec_ctrl.sh_type = SH_ROR;
      dec_ctrl.pass    = (shift_operand[11:8] == 4'd0);
      dec_ctrl.amt     = AMT_W'({shift_operand[11:8], 1'b0});
    end else if (n_amt == 8'd0) begin
      if (shift_operand[4] || dec_ctrl.sh_type == SH_LSL) begin
        dec_ctrl.pass = 1'b1;
      end else if (dec_ctrl.sh_type == SH_ROR) begin
        dec_ctrl.rrx = 1'b1;
      end else begin
        dec_ctrl.amt = AMT_W'(DATA_W);
      end
    end else if (dec_ctrl.sh_type == SH_ROR) begin
      dec_ctrl.amt = AMT_W'(n_amt);
    end else if (n_amt >= 8'(DATA_W)) begin
      dec_ctrl.amt  = AMT_W'(DATA_W);
      dec_ctrl.over = (n_amt > 8'(DATA_W));
    end else begin
      dec_ctrl.amt = AMT_W'(n_amt);
    end
  end

  assign out_adv  = !out_vld_q | out_ready;
  assign out_load = out_adv & ex_vld;

  generate
    if (PIPE_DEPTH == 2) begin : g_two
      shift_ctrl_t       s1_ctrl_q, s1_ctrl_d;
      logic [DATA_W-1:0] s1_rm_q, s1_rm_d;
      logic              s1_vld_q, s1_vld_d;
      logic              s1_adv;

      assign s1_adv   = !s1_vld_q | out_adv;
      assign in_ready = s1_adv;
      assign ex_ctrl  = s1_ctrl_q;
      assign ex_rm    = s1_rm_q;
      assign ex_vld   = s1_vld_q;

      always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_ctrl_d = s1_ctrl_q;
        s1_rm_d   = s1_rm_q;
        if (s1_adv) begin
          s1_vld_d = in_valid;
        end
        if (s1_adv && in_valid) begin
          s1_ctrl_d = dec_ctrl;
          s1_rm_d   = dec_rm;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_vld_q  <= 1'b0;
          s1_ctrl_q <= '0;
          s1_rm_q   <= '0;
        end else begin
          s1_vld_q  <= s1_vld_d;
          s1_ctrl_q <= s1_ctrl_d;
          s1_rm_q   <= s1_rm_d;
        end
      end
    end else begin : g_one
      assign in_ready = out_adv;
      assign ex_ctrl  = dec_ctrl;
      assign ex_rm    = dec_rm;
      assign ex_vld   = in_valid;
    end
  endgenerate

  // Extended shifts carry the last bit shifted out alongside the result
  assign lsl_ext = {1'b0, ex_rm} << ex_ctrl.amt;
  assign lsr_ext = {ex_rm, 1'b0} >> ex_ctrl.amt;
  assign asr_ext = $signed({ex_rm, 1'b0}) >>> ex_ctrl.amt;

  rot_right #(
    .DATA_W (DATA_W),
    .AMT_W  (LW)
  ) u_rot (
    .data_i (ex_rm),
    .amt_i  (ex_ctrl.amt[LW-1:0]),
    .data_o (ror_val)
  );

  always_comb begin
    res_val = ex_rm;
    res_c   = ex_ctrl.cin;
    if (ex_ctrl.pass) begin
      res_val = ex_rm;
    end else if (ex_ctrl.rrx) begin
      res_val = {ex_ctrl.cin, ex_rm[DATA_W-1:1]};
      res_c   = ex_rm[0];
    end else begin
      case (ex_ctrl.sh_type)
        SH_LSL: begin
          if (ex_ctrl.over) begin
            res_val = '0;
            res_c   = 1'b0;
          end else begin
            {res_c, res_val} = lsl_ext;
          end
        end
        SH_LSR: begin
          if (ex_ctrl.over) begin
            res_val = '0;
            res_c   = 1'b0;
          end else begin
            {res_val, res_c} = lsr_ext;
          end
        end
        SH_ASR: {res_val, res_c} = asr_ext;
        SH_ROR: begin
          res_val = ror_val;
          res_c   = ror_val[DATA_W-1];
        end
        default: res_val = ex_rm;
      endcase
    end
  end

  always_comb begin
    out_vld_d = out_vld_q;
    val2_d    = val2_q;
    if (out_adv) begin
      out_vld_d = ex_vld;
    end
    if (out_load) begin
      val2_d = res_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld_q <= 1'b0;
      val2_q    <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      val2_q    <= val2_d;
    end
  end

`ifdef SHIFTER_CARRY_EN
  logic carry_q, carry_d;

  always_comb begin
    carry_d = carry_q;
    if (out_load) begin
      carry_d = res_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry_d;
    end
  end

  assign carry_out = carry_q;
`else
  assign carry_out = 1'b0;
`endif

  assign out_valid = out_vld_q;
  assign val2      = val2_q;

endmodule

// File: tb/tb_shifter_operand_unit.sv
// Directed bench for shifter_operand_unit (DATA_W=32, PIPE_DEPTH=2); carry
// expectations follow whether SHIFTER_CARRY_EN is defined.
module tb_shifter_operand_unit;

`ifdef SHIFTER_CARRY_EN
  localparam logic CE = 1'b1;
`else
  localparam logic CE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        imm_en;
  logic [11:0] shift_operand;
  logic [31:0] val_rm;
  logic [7:0]  val_rs;
  logic        carry_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] val2;
  logic        carry_out;

  int checks = 0;
  int errors = 0;

  logic [31:0] srm  [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
  logic [31:0] sexp [4] = '{32'h22, 32'h44, 32'h66, 32'h88};

  shifter_operand_unit #(
    .DATA_W     (32),
    .PIPE_DEPTH (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .imm_en        (imm_en),
    .shift_operand (shift_operand),
    .val_rm        (val_rm),
    .val_rs        (val_rs),
    .carry_in      (carry_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .val2          (val2),
    .carry_out     (carry_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request with out_ready held high: checks acceptance, latency and result
  task automatic run_one(input string tag, input logic ie, input logic [11:0] op,
                         input logic [31:0] rm, input logic [7:0] rs, input logic ci,
                         input logic [31:0] ev, input logic ec);
    @(negedge clk);
    imm_en        = ie;
    shift_operand = op;
    val_rm        = rm;
    val_rs        = rs;
    carry_in      = ci;
    out_ready     = 1'b1;
    in_valid      = 1'b1;
    #1 chk({tag, "_rdy"}, 64'(in_ready), 64'(1'b1));
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk({tag, "_lat"}, 64'(out_valid), 64'(1'b0));
    @(negedge clk);
    chk({tag, "_vld"}, 64'(out_valid), 64'(1'b1));
    chk({tag, "_val"}, 64'(val2), 64'(ev));
    chk({tag, "_c"}, 64'(carry_out), 64'(ec));
  endtask

  initial begin
    int   tx;
    int   rx;
    int   leaked;
    bit   stall_seen;
    logic acc;
    logic pop;

    rst           = 1'b1;
    in_valid      = 1'b0;
    out_ready     = 1'b0;
    imm_en        = 1'b0;
    shift_operand = 12'h000;
    val_rm        = 32'h0;
    val_rs        = 8'h0;
    carry_in      = 1'b0;
    #1;
    chk("rst_vld", 64'(out_valid), 64'(1'b0));
    chk("rst_val", 64'(val2), 64'(32'h0));
    chk("rst_c", 64'(carry_out), 64'(1'b0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_rdy", 64'(in_ready), 64'(1'b1));

    run_one("imm4ff", 1'b1, 12'h4FF, 32'h0, 8'h0, 1'b0, 32'hFF000000, CE);
    run_one("imm0ab", 1'b1, 12'h0AB, 32'h0, 8'h0, 1'b1, 32'h000000AB, CE);
    run_one("lslr32", 1'b0, 12'h010, 32'h00000001, 8'd32, 1'b0, 32'h0, CE);
    run_one("lslr33", 1'b0, 12'h010, 32'h00000001, 8'd33, 1'b1, 32'h0, 1'b0);
    run_one("rrx", 1'b0, 12'h060, 32'h00000003, 8'h0, 1'b1,
            CE ? 32'h80000001 : 32'h00000001, CE);
    run_one("asri0", 1'b0, 12'h040, 32'h80000000, 8'h0, 1'b0, 32'hFFFFFFFF, CE);
    run_one("lsri0", 1'b0, 12'h020, 32'h80000000, 8'h0, 1'b0, 32'h0, CE);
    run_one("lsli0", 1'b0, 12'h000, 32'h5A5A5A5A, 8'h0, 1'b0, 32'h5A5A5A5A, 1'b0);
    run_one("lsli4", 1'b0, 12'h200, 32'h12345678, 8'h0, 1'b0, 32'h23456780, CE);
    run_one("lsri8", 1'b0, 12'h420, 32'h12345678, 8'h0, 1'b1, 32'h00123456, 1'b0);
    run_one("asrr4", 1'b0, 12'h050, 32'h80000008, 8'd4, 1'b0, 32'hF8000000, CE);
    run_one("asrr200", 1'b0, 12'h050, 32'h7FFFFFFF, 8'd200, 1'b1, 32'h0, 1'b0);
    run_one("rorr36", 1'b0, 12'h070, 32'h0000000F, 8'd36, 1'b0, 32'hF0000000, CE);
    run_one("rorr32", 1'b0, 12'h070, 32'h80000001, 8'd32, 1'b0, 32'h80000001, CE);
    run_one("regamt0", 1'b0, 12'h050, 32'hDEADBEEF, 8'd0, 1'b1, 32'hDEADBEEF, CE);
    run_one("lsrr32", 1'b0, 12'h030, 32'h80000000, 8'd32, 1'b0, 32'h0, CE);
    run_one("lsrr40", 1'b0, 12'h030, 32'h80000000, 8'd40, 1'b1, 32'h0, 1'b0);

    // Back-to-back stream with a three-cycle consumer stall
    tx         = 0;
    rx         = 0;
    stall_seen = 1'b0;
    @(negedge clk);
    imm_en        = 1'b0;
    shift_operand = 12'h080;
    carry_in      = 1'b0;
    val_rm        = srm[0];
    in_valid      = 1'b1;
    for (int c = 0; c < 40 && rx < 4; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      #1;
      acc = in_valid & in_ready;
      pop = out_valid & out_ready;
      if (in_valid && !in_ready) stall_seen = 1'b1;
      if (out_valid && rx < 4) chk($sformatf("strm%0d", rx), 64'(val2), 64'(sexp[rx]));
      if (pop) rx++;
      @(posedge clk);
      #1;
      if (acc) begin
        tx++;
        if (tx < 4) val_rm = srm[tx];
        else in_valid = 1'b0;
      end
      @(negedge clk);
    end
    #1;
    chk("strm_rx", 64'(rx), 64'(4));
    chk("strm_tx", 64'(tx), 64'(4));
    chk("strm_stall", 64'(stall_seen), 64'(1'b1));
    chk("strm_drain", 64'(out_valid), 64'(1'b0));

    // Reset with two requests in flight
    @(negedge clk);
    out_ready     = 1'b0;
    shift_operand = 12'h080;
    val_rm        = 32'h1;
    in_valid      = 1'b1;
    @(posedge clk);
    #1 val_rm = 32'h2;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("rstm_pre", 64'(out_valid), 64'(1'b1));
    rst = 1'b1;
    #1;
    chk("rstm_vld", 64'(out_valid), 64'(1'b0));
    chk("rstm_val", 64'(val2), 64'(32'h0));
    chk("rstm_rdy", 64'(in_ready), 64'(1'b1));
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    leaked    = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) leaked++;
    end
    chk("rstm_leak", 64'(leaked), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shifter_operand_unit.md
SHIFTER_OPERAND_UNIT -- requirements
Module: shifter_operand_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand width; legal values 16, 32, 64.
REQ-002 SHALL have parameter PIPE_DEPTH, default 2, number of register stages (1 or 2).
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  request present.
REQ-006 in_ready  out  1  unit accepts request this cycle.
REQ-007 imm_en  in  1  1 = rotated-immediate operand, 0 = shifted register.
REQ-008 shift_operand  in  12  immediate or shift field.
REQ-009 val_rm  in  DATA_W  Rm value.
REQ-010 val_rs  in  8  Rs[7:0], register-specified shift amount.
REQ-011 carry_in  in  1  current C flag.
REQ-012 out_valid  out  1  result present.
REQ-013 out_ready  in  1  consumer accepts result.
REQ-014 val2  out  DATA_W  operand-2 result.
REQ-015 carry_out  out  1  shifter carry.

Function
REQ-016 Transfer SHALL occur on in_valid&in_ready (input) and out_valid&out_ready (output).
REQ-017 Latency SHALL be exactly PIPE_DEPTH cycles from accept to out_valid with no stall; throughput one per cycle.
REQ-018 in_ready SHALL equal !stage_full[last] | out_ready propagated back (bubbles collapse; a stage loads when it or every later stage can advance).
REQ-019 Held outputs SHALL remain stable while out_valid&!out_ready.
REQ-020 imm_en=1: val2 SHALL be zero-extended imm[7:0] rotated right by 2*imm[11:8] within DATA_W; carry_out = carry_in if rotate 0, else val2[DATA_W-1].
REQ-021 imm_en=0, shift_operand[4]=0: amount = shift_operand[11:7], type = shift_operand[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR).
REQ-022 Immediate amount 0: LSL #0 passes val_rm with carry_in; LSR #0 means LSR DATA_W; ASR #0 means ASR DATA_W; ROR #0 means RRX ({carry_in, val_rm[DATA_W-1:1]}, carry_out = val_rm[0]).
REQ-023 imm_en=0, shift_operand[4]=1: amount = val_rs[7:0] (0..255), same type encoding.
REQ-024 Register amount 0: val2 = val_rm, carry_out = carry_in, all types.
REQ-025 LSL n: n<DATA_W normal, carry = val_rm[DATA_W-n]; n=DATA_W -> 0, carry val_rm[0]; n>DATA_W -> 0, carry 0.
REQ-026 LSR n: n=DATA_W -> 0, carry val_rm[DATA_W-1]; n>DATA_W -> 0, carry 0.
REQ-027 ASR n>=DATA_W: all bits and carry = val_rm[DATA_W-1].
REQ-028 ROR n: rotate by n mod DATA_W; if n mod DATA_W = 0 (n!=0) val2 = val_rm, carry = val_rm[DATA_W-1].
REQ-029 Stage 1 SHALL decode type/effective amount; last stage SHALL register val2/carry_out.

Reset
REQ-030 rst SHALL asynchronously clear all stage valid bits, out_valid=0, val2=0, carry_out=0; in_ready=1 from first edge after release.
REQ-031 Reset mid-operation SHALL discard in-flight requests without emitting them.

Configuration
REQ-032 SHIFTER_CARRY_EN defined: carry_in used and carry_out driven per REQ-020..028.
REQ-033 SHIFTER_CARRY_EN undefined: carry logic removed, carry_out tied 0, RRX treats carry_in as 0.

Structure
REQ-034 Package shifter_pkg SHALL hold shift-type enum (LSL/LSR/ASR/ROR) and DATA_W default constant.
REQ-035 Sub-module rot_right (combinational, parametrised DATA_W rotate-right with amount) SHALL be reused for immediate rotate and ROR.

Verification
REQ-036 imm_en=1, shift_operand=0x4FF -> val2=0xFF000000, carry_out=1, after 2 cycles.
REQ-037 Reg shift LSL, val_rs=32, val_rm=0x00000001 -> val2=0, carry_out=1; val_rs=33 -> val2=0, carry_out=0.
REQ-038 shift_operand=0x060 (ROR #0), val_rm=0x00000003, carry_in=1 -> val2=0x80000001, carry_out=1.
REQ-039 ASR #0 immediate, val_rm=0x80000000 -> val2=0xFFFFFFFF, carry_out=1.
REQ-040 Back-to-back 4 requests, out_ready low 3 cycles mid-stream -> in_ready drops, no loss/duplication, order kept.
REQ-041 rst pulse with 2 requests in flight -> out_valid=0 immediately, neither emitted.
